st_crossbar: RTL and testbench
==============================

# st_crossbar

Registered, back-pressured switch-traversal crossbar for the router datapath: successor of the combinational `crossbar`, generalised to arbitrary INPUT_NUM × OUTPUT_NUM with per-output valid/ready flow control and a BUF_DEPTH-entry output queue per port. Sits between the switch allocator (drives `sel_i`/`req_i`) and the output links. Supports multicast (several outputs selecting one input) and flags illegal selects.

## Interface
- INPUT_NUM, 5, number of input ports (≥2, need not be a power of 2)
- OUTPUT_NUM, 5, number of output ports (≥1)
- BUF_DEPTH, 2, entries per output queue (power of 2, ≥2)
- SEL_SIZE, $clog2(INPUT_NUM), localparam, select width
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- data_i  in  flit_t [INPUT_NUM]  input flits
- sel_i  in  SEL_SIZE [OUTPUT_NUM]  input index routed to each output
- req_i  in  1 [OUTPUT_NUM]  allocator grant: push data_i[sel_i[o]] into output o
- ready_o  out  1 [OUTPUT_NUM]  output queue o not full
- data_o  out  flit_t [OUTPUT_NUM]  head flit of output queue o
- valid_o  out  1 [OUTPUT_NUM]  data_o[o] valid
- ready_i  in  1 [OUTPUT_NUM]  downstream accepts data_o[o]
- err_o  out  1  sticky illegal-select flag

## Operation
- Push on output o when req_i[o] & ready_o[o] & sel_i[o] < INPUT_NUM; flit written is data_i[sel_i[o]] sampled that edge.
- req_i[o] with ready_o[o]=0: request ignored, no push, no error; allocator is responsible for not granting.
- req_i[o] with sel_i[o] ≥ INPUT_NUM: no push, err_o set to 1 at next edge, stays 1 until reset.
- Pop on output o when valid_o[o] & ready_i[o]; head advances.
- Multicast: any number of outputs may select the same input in one cycle; each receives an identical copy.
- Per-output queue: write pointer, read pointer, occupancy count (width $clog2(BUF_DEPTH)+1); pointers wrap modulo BUF_DEPTH.
- ready_o[o] = (count[o] != BUF_DEPTH); valid_o[o] = (count[o] != 0); both derived from registered count only.
- Simultaneous push and pop on non-empty queue: count unchanged, both pointers advance.
- Flit content passes unmodified; no inspection of flit_label.

## Timing
- Reset (async assert, sync-safe deassert via clk): all counts and pointers 0, valid_o=0, ready_o=1, err_o=0, data_o=0 (storage cleared).
- Latency: pushed flit appears on data_o with valid_o=1 the cycle after push when queue was empty.
- Throughput: one flit per output per cycle sustained when ready_i held high.
- No combinational path from ready_i or req_i to ready_o; ready_i→valid_o also registered.
- Full queue with ready_i=1: ready_o still 0 that cycle; pop occurs, ready_o=1 next cycle.
- Reset asserted mid-transfer: queued flits discarded immediately, outputs return to reset values asynchronously.

## Structure
- flit_t, flit_label_t, VC/coordinate widths remain in noc_params; no new package types.
- Sub-module `xbar_out_fifo` (flit_t queue, BUF_DEPTH param, push/pop, valid/ready) instantiated OUTPUT_NUM times via generate; top level holds select muxes, select-range check and err_o register.

## Test plan
- Reset: rst=0 then release → valid_o all 0, ready_o all 1, err_o 0, data_o 0.
- Permutation: 4 cycles with sel_i[o]=(o+k)%INPUT_NUM, req_i all 1, ready_i all 1, data_i[i] HEAD vc_id=i → each cycle+1 data_o[o].vc_id=(o+k)%INPUT_NUM.
- Multicast: sel_i all 2, req_i all 1, data_i[2] head_pl=0xA5 → next cycle every data_o head_pl=0xA5, valid_o all 1.
- Backpressure: ready_i[0]=0, push 3 flits to output 0 with BUF_DEPTH=2 → only first 2 accepted, ready_o[0]=0 after second; raise ready_i[0] → flits drain in order 1,2, ready_o[0]=1 one cycle after first pop.
- Illegal select (INPUT_NUM=5): sel_i[1]=7, req_i[1]=1 → no push on output 1, err_o=1 next cycle and remains 1 after sel_i corrected.
- Reset mid-operation: queues full, assert rst between edges → valid_o drops to 0 before next clk edge; after release new push delivers only new flit.

Source files
------------

// File: rtl/noc_params.sv
// Shared NoC datapath types: flit layout and field widths used by the router.
package noc_params;

  localparam int VC_SIZE      = 3;
  localparam int HEAD_PL_SIZE = 8;
  localparam int BODY_PL_SIZE = 16;

  typedef enum logic [1:0] {
    HEAD     = 2'd0,
    BODY     = 2'd1,
    TAIL     = 2'd2,
    HEADTAIL = 2'd3
  } flit_label_t;

  typedef struct packed {
    flit_label_t              flit_label;
    logic [VC_SIZE-1:0]       vc_id;
    logic [HEAD_PL_SIZE-1:0]  head_pl;
    logic [BODY_PL_SIZE-1:0]  body_pl;
  } flit_t;

endpackage

// File: rtl/xbar_out_fifo.sv
// Per-output flit queue of the crossbar: circular buffer with valid/ready on
// both sides. ready_o and valid_o are decoded from the registered occupancy
// only, so neither depends combinationally on push_i or ready_i.
module xbar_out_fifo
  import noc_params::*;
#(
  parameter int BUF_DEPTH = 2
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push_i,
  input  flit_t data_i,
  output logic  ready_o,
  output flit_t data_o,
  output logic  valid_o,
  input  logic  ready_i
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUF_DEPTH);

  flit_t            r_mem [BUF_DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign ready_o = (r_count != FULL_CNT);
  assign valid_o = (r_count != '0);
  assign w_push  = push_i & ready_o;
  assign w_pop   = valid_o & ready_i;
  assign data_o  = r_mem[r_rdPtr];

  // Storage, pointers and occupancy; reset wipes stored flits so data_o reads 0.
  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wrPtr] <= data_i;
        r_wrPtr        <= r_wrPtr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/st_crossbar.sv
// Registered switch-traversal crossbar: per-output input select mux feeding a
// small output queue, with a sticky flag for out-of-range selects.
module st_crossbar
  import noc_params::*;
#(
  parameter  int INPUT_NUM  = 5,
  parameter  int OUTPUT_NUM = 5,
  parameter  int BUF_DEPTH  = 2,
  localparam int SEL_SIZE   = $clog2(INPUT_NUM)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  flit_t [INPUT_NUM-1:0]              data_i,
  input  logic  [OUTPUT_NUM-1:0][SEL_SIZE-1:0] sel_i,
  input  logic  [OUTPUT_NUM-1:0]             req_i,
  output logic  [OUTPUT_NUM-1:0]             ready_o,
  output flit_t [OUTPUT_NUM-1:0]             data_o,
  output logic  [OUTPUT_NUM-1:0]             valid_o,
  input  logic  [OUTPUT_NUM-1:0]             ready_i,
  output logic                               err_o
);

  flit_t [OUTPUT_NUM-1:0] w_muxData;
  logic  [OUTPUT_NUM-1:0] w_selOk;
  logic  [OUTPUT_NUM-1:0] w_push;
  logic                   r_err;

  // Select mux per output; a select that matches no input index is illegal,
  // which also covers the unused codes when INPUT_NUM is not a power of two.
  always_comb begin
    w_muxData = '0;
    w_selOk   = '0;
    for (int o = 0; o < OUTPUT_NUM; o++) begin
      for (int i = 0; i < INPUT_NUM; i++) begin
        if (sel_i[o] == SEL_SIZE'(i)) begin
          w_muxData[o] = data_i[i];
          w_selOk[o]   = 1'b1;
        end
      end
    end
  end

  assign w_push = req_i & w_selOk;
  assign err_o  = r_err;

  // Sticky illegal-select flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else if (|(req_i & ~w_selOk)) begin
      r_err <= 1'b1;
    end
  end

  for (genvar o = 0; o < OUTPUT_NUM; o++) begin : g_out
    xbar_out_fifo #(
      .BUF_DEPTH(BUF_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (w_push[o]),
      .data_i  (w_muxData[o]),
      .ready_o (ready_o[o]),
      .data_o  (data_o[o]),
      .valid_o (valid_o[o]),
      .ready_i (ready_i[o])
    );
  end

endmodule

// File: tb/tb_st_crossbar.sv
// Scoreboard bench for st_crossbar: stimulus predicts accepted flits into
// per-output queues, a negedge monitor checks outputs and retires popped flits.
module tb_st_crossbar;
  import noc_params::*;

  localparam int IN    = 5;
  localparam int OUT   = 5;
  localparam int DEPTH = 2;

  logic                  clk;
  logic                  rst;
  flit_t [IN-1:0]        dataI;
  logic  [OUT-1:0][2:0]  selI;
  logic  [OUT-1:0]       reqI;
  logic  [OUT-1:0]       readyO;
  flit_t [OUT-1:0]       dataO;
  logic  [OUT-1:0]       validO;
  logic  [OUT-1:0]       readyI;
  logic                  errO;

  flit_t sbq [OUT][$];
  logic  pendPush [OUT];
  flit_t pendFlit [OUT];
  logic  pendErr;
  logic  errModel;

  int totalCnt = 0;
  int badCnt   = 0;

  st_crossbar #(
    .INPUT_NUM (IN),
    .OUTPUT_NUM(OUT),
    .BUF_DEPTH (DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .data_i  (dataI),
    .sel_i   (selI),
    .req_i   (reqI),
    .ready_o (readyO),
    .data_o  (dataO),
    .valid_o (validO),
    .ready_i (readyI),
    .err_o   (errO)
  );

  initial clk = 1'b0;
  // Free-running clock, period 10.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int idx,
                             input logic [63:0] act, input logic [63:0] exp);
    totalCnt++;
    if (act !== exp) begin
      badCnt++;
      $display("[TB] FAIL %s[%0d] got=%h want=%h at %0t", name, idx, act, exp, $time);
    end
  endtask

  function automatic flit_t randFlit();
    flit_t f;
    f.flit_label = flit_label_t'($urandom_range(0, 3));
    f.vc_id      = 3'($urandom_range(0, 7));
    f.head_pl    = 8'($urandom);
    f.body_pl    = 16'($urandom);
    return f;
  endfunction

  // Drive one cycle of inputs after the edge and predict what the next edge accepts.
  task automatic applyStimulus(input logic [OUT-1:0] reqV,
                               input logic [OUT-1:0][2:0] selV,
                               input flit_t [IN-1:0] dataV,
                               input logic [OUT-1:0] rdyV);
    @(posedge clk);
    #2;
    reqI   = reqV;
    selI   = selV;
    dataI  = dataV;
    readyI = rdyV;
    for (int o = 0; o < OUT; o++) begin
      if (reqV[o]) begin
        int s;
        s = int'(selV[o]);
        if (s >= IN) begin
          pendErr = 1'b1;
        end else if (sbq[o].size() < DEPTH) begin
          pendPush[o] = 1'b1;
          pendFlit[o] = dataV[s];
        end
      end
    end
  endtask

  // Assert reset between edges, check the outputs clear immediately, release later.
  task automatic doReset();
    @(posedge clk);
    #2;
    rst  = 1'b0;
    reqI = '0;
    for (int o = 0; o < OUT; o++) begin
      sbq[o].delete();
      pendPush[o] = 1'b0;
    end
    pendErr  = 1'b0;
    errModel = 1'b0;
    #1;
    checkOutput("rstValid", 0, 64'(validO), 64'(0));
    checkOutput("rstReady", 0, 64'(readyO), 64'({OUT{1'b1}}));
    checkOutput("rstErr",   0, 64'(errO),   64'(0));
    for (int o = 0; o < OUT; o++) begin
      checkOutput("rstData", o, 64'(dataO[o]), 64'(0));
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  // Move predicted pushes and error into the model just after the edge they take effect.
  always @(posedge clk) begin
    #1;
    for (int o = 0; o < OUT; o++) begin
      if (pendPush[o]) begin
        sbq[o].push_back(pendFlit[o]);
      end
      pendPush[o] = 1'b0;
    end
    if (pendErr) begin
      errModel = 1'b1;
    end
    pendErr = 1'b0;
  end

  // Monitor: compare flags and head flit, retire the head when a pop will happen.
  always @(negedge clk) begin
    for (int o = 0; o < OUT; o++) begin
      checkOutput("valid", o, 64'(validO[o]), 64'(sbq[o].size() != 0));
      checkOutput("ready", o, 64'(readyO[o]), 64'(sbq[o].size() < DEPTH));
      if (sbq[o].size() != 0) begin
        checkOutput("data", o, 64'(dataO[o]), 64'(sbq[o][0]));
        if (readyI[o]) begin
          void'(sbq[o].pop_front());
        end
      end
    end
    checkOutput("err", 0, 64'(errO), 64'(errModel));
  end

  initial begin
    logic  [OUT-1:0]      reqV;
    logic  [OUT-1:0][2:0] selV;
    flit_t [IN-1:0]       dataV;
    logic  [OUT-1:0]      rdyV;

    rst      = 1'b1;
    reqI     = '0;
    selI     = '0;
    dataI    = '0;
    readyI   = '1;
    pendErr  = 1'b0;
    errModel = 1'b0;
    for (int o = 0; o < OUT; o++) pendPush[o] = 1'b0;
    #3;
    rst = 1'b0;
    #1;
    checkOutput("initValid", 0, 64'(validO), 64'(0));
    checkOutput("initReady", 0, 64'(readyO), 64'({OUT{1'b1}}));
    checkOutput("initErr",   0, 64'(errO),   64'(0));
    doReset();

    // Rotating permutation with HEAD flits tagged by input index.
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < IN; i++) begin
        dataV[i] = randFlit();
        dataV[i].flit_label = HEAD;
        dataV[i].vc_id      = 3'(i);
      end
      for (int o = 0; o < OUT; o++) selV[o] = 3'((o + k) % IN);
      applyStimulus('1, selV, dataV, '1);
    end

    // Multicast of input 2 to every output.
    for (int i = 0; i < IN; i++) dataV[i] = randFlit();
    dataV[2].head_pl = 8'hA5;
    for (int o = 0; o < OUT; o++) selV[o] = 3'd2;
    applyStimulus('1, selV, dataV, '1);
    applyStimulus('0, selV, dataV, '1);
    applyStimulus('0, selV, dataV, '1);

    // Backpressure on output 0: three requests, only two fit.
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < IN; i++) dataV[i] = randFlit();
      dataV[0].body_pl = 16'(n + 1);
      selV = '0;
      applyStimulus(5'b00001, selV, dataV, 5'b11110);
    end
    applyStimulus('0, selV, dataV, 5'b11110);
    for (int n = 0; n < 4; n++) applyStimulus('0, selV, dataV, '1);

    // Illegal select on output 1, then corrected.
    selV    = '0;
    selV[1] = 3'd7;
    applyStimulus(5'b00010, selV, dataV, '1);
    selV[1] = 3'd1;
    for (int n = 0; n < 3; n++) applyStimulus('0, selV, dataV, '1);

    // Fill every queue, then reset mid-operation.
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < IN; i++) dataV[i] = randFlit();
      for (int o = 0; o < OUT; o++) selV[o] = 3'($urandom_range(0, IN - 1));
      applyStimulus('1, selV, dataV, '0);
    end
    doReset();
    for (int i = 0; i < IN; i++) dataV[i] = randFlit();
    for (int o = 0; o < OUT; o++) selV[o] = 3'(o % IN);
    applyStimulus('1, selV, dataV, '1);
    for (int n = 0; n < 3; n++) applyStimulus('0, selV, dataV, '1);

    // Randomized traffic with random backpressure and rare illegal selects.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < IN; i++) dataV[i] = randFlit();
      for (int o = 0; o < OUT; o++) begin
        reqV[o] = 1'($urandom_range(0, 1));
        selV[o] = ($urandom_range(0, 29) == 0) ? 3'($urandom_range(IN, 7))
                                               : 3'($urandom_range(0, IN - 1));
        rdyV[o] = ($urandom_range(0, 3) != 0);
      end
      applyStimulus(reqV, selV, dataV, rdyV);
    end
    for (int n = 0; n < 4; n++) applyStimulus('0, selV, dataV, '1);

    @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
    $finish;
  end

endmodule
